seg_scan_driver: RTL and testbench

- Display back end for the reaction-timer top level: takes the measured binary time value and drives the 4-digit multiplexed 7-segment display (AN digit enables, leds segments).
- Converts binary to BCD with a sequential shift-add-3 (double-dabble) engine, holds the result, and time-multiplexes the four digits.
- Leading-zero blanking and a global blank input are provided.

---
 rtl/seg_scan_driver.sv | 158 +++++++++++++++
 tb/tb_seg_scan_driver.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver.sv
// Binary-to-BCD (sequential double-dabble) plus 4-digit multiplexed 7-segment scan driver.
// AN and leds are registered from the current digit index and the held BCD result.
module seg_scan_driver #(
  parameter int unsigned SCAN_DIV = 100000,
  parameter bit          LZB      = 1'b1
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic        load,
  input  logic [13:0] value,
  input  logic        blank,
  output logic        busy,
  output logic [15:0] bcd,
  output logic [3:0]  AN,
  output logic [7:0]  leds
);

  localparam int unsigned VAL_W = 14;
  localparam int unsigned BCD_W = 16;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(VAL_W - 1);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
  localparam logic [VAL_W-1:0] SAT_MAX   = VAL_W'(9999);

  typedef enum logic {IDLE, CONV} state_t;

  state_t             state, state_n;
  logic [VAL_W-1:0]   sh, sh_n;
  logic [BCD_W-1:0]   acc, acc_n, adj;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [BCD_W-1:0]   bcd_n;
  logic               busy_n;

  logic [DIV_W-1:0]   div;
  logic [1:0]         idx;
  logic [3:0]         nib_c;
  logic               blanked_c;
  logic [3:0]         an_c;
  logic [7:0]         leds_c;

  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

  function automatic logic [7:0] seg(input logic [3:0] d);
    case (d)
      4'd0: seg = 8'hC0;
      4'd1: seg = 8'hF9;
      4'd2: seg = 8'hA4;
      4'd3: seg = 8'hB0;
      4'd4: seg = 8'h99;
      4'd5: seg = 8'h92;
      4'd6: seg = 8'h82;
      4'd7: seg = 8'hF8;
      4'd8: seg = 8'h80;
      4'd9: seg = 8'h90;
      default: seg = 8'hFF;
    endcase
  endfunction

  // Conversion state and datapath registers
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      sh    <= '0;
      acc   <= '0;
      cnt   <= '0;
      bcd   <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_n;
      sh    <= sh_n;
      acc   <= acc_n;
      cnt   <= cnt_n;
      bcd   <= bcd_n;
      busy  <= busy_n;
    end
  end

  // Next-state: capture on load, then 14 add-3/shift steps; bcd only changes on the final step
  always_comb begin
    state_n = state;
    sh_n    = sh;
    acc_n   = acc;
    cnt_n   = cnt;
    bcd_n   = bcd;
    busy_n  = busy;
    adj     = {add3(acc[15:12]), add3(acc[11:8]), add3(acc[7:4]), add3(acc[3:0])};
    case (state)
      IDLE: begin
        if (load) begin
          sh_n    = (value > SAT_MAX) ? SAT_MAX : value;
          acc_n   = '0;
          cnt_n   = '0;
          busy_n  = 1'b1;
          state_n = CONV;
        end
      end
      CONV: begin
        {acc_n, sh_n} = {adj, sh} << 1;
        cnt_n = cnt + CNT_W'(1);
        if (cnt == LAST_STEP) begin
          bcd_n   = acc_n;
          busy_n  = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Scan divider and digit index
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      div <= '0;
      idx <= '0;
    end else if (div == DIV_LAST) begin
      div <= '0;
      idx <= idx + 2'd1;
    end else begin
      div <= div + DIV_W'(1);
    end
  end

  always_comb begin
    nib_c     = 4'd0;
    blanked_c = blank;
    case (idx)
      2'd0: nib_c = bcd[3:0];
      2'd1: begin
        nib_c = bcd[7:4];
        if (LZB && bcd[15:4] == 12'd0) blanked_c = 1'b1;
      end
      2'd2: begin
        nib_c = bcd[11:8];
        if (LZB && bcd[15:8] == 8'd0) blanked_c = 1'b1;
      end
      default: begin
        nib_c = bcd[15:12];
        if (LZB && bcd[15:12] == 4'd0) blanked_c = 1'b1;
      end
    endcase
    an_c   = blanked_c ? 4'b1111 : ~(4'b0001 << idx);
    leds_c = blanked_c ? 8'hFF : seg(nib_c);
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      AN   <= 4'b1111;
      leds <= 8'hFF;
    end else begin
      AN   <= an_c;
      leds <= leds_c;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver: SCAN_DIV=4, one LZB=1 and one LZB=0 instance.
module tb_seg_scan_driver;

  logic        sysclk = 1'b0;
  logic        reset  = 1'b1;
  logic        load   = 1'b0;
  logic        blank  = 1'b0;
  logic [13:0] value  = '0;

  logic        busy_a, busy_b;
  logic [15:0] bcd_a, bcd_b;
  logic [3:0]  an_a, an_b;
  logic [7:0]  leds_a, leds_b;

  int vectors     = 0;
  int miscompares = 0;
  int n;
  logic [15:0] sb[$];

  seg_scan_driver #(.SCAN_DIV(4), .LZB(1'b1)) dut_a (
    .sysclk(sysclk), .reset(reset), .load(load), .value(value), .blank(blank),
    .busy(busy_a), .bcd(bcd_a), .AN(an_a), .leds(leds_a)
  );

  seg_scan_driver #(.SCAN_DIV(4), .LZB(1'b0)) dut_b (
    .sysclk(sysclk), .reset(reset), .load(load), .value(value), .blank(blank),
    .busy(busy_b), .bcd(bcd_b), .AN(an_b), .leds(leds_b)
  );

  always #5 sysclk = ~sysclk;

  // Edges since reset release; slot phase is derived from this
  always @(posedge sysclk or posedge reset) begin
    if (reset) n <= 0;
    else       n <= n + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] seg_ref(input logic [3:0] d);
    case (d)
      4'd0: return 8'hC0;  4'd1: return 8'hF9;  4'd2: return 8'hA4;
      4'd3: return 8'hB0;  4'd4: return 8'h99;  4'd5: return 8'h92;
      4'd6: return 8'h82;  4'd7: return 8'hF8;  4'd8: return 8'h80;
      4'd9: return 8'h90;  default: return 8'hFF;
    endcase
  endfunction

  // Expected {AN, leds} sampled after edge nn
  function automatic logic [11:0] exp_out(input int nn, input logic [15:0] b,
                                          input bit lzb, input bit blk);
    int d;
    logic [3:0] nib;
    logic [3:0] an;
    bit off;
    d   = ((nn - 1) / 4) % 4;
    nib = b[d*4 +: 4];
    off = blk || (lzb && ((d == 3 && b[15:12] == 4'd0) ||
                          (d == 2 && b[15:8] == 8'd0) ||
                          (d == 1 && b[15:4] == 12'd0)));
    an  = ~(4'b0001 << d);
    return off ? 12'hFFF : {an, seg_ref(nib)};
  endfunction

  task automatic check_disp(input int cycles, input logic [15:0] b,
                            input int bon, input int boff);
    for (int i = 0; i < cycles; i++) begin
      @(negedge sysclk);
      chk("disp_lzb1", {20'd0, an_a, leds_a}, {20'd0, exp_out(n, b, 1'b1, blank)});
      chk("disp_lzb0", {20'd0, an_b, leds_b}, {20'd0, exp_out(n, b, 1'b0, blank)});
      if (i == bon)  blank = 1'b1;
      if (i == boff) blank = 1'b0;
    end
  endtask

  task automatic start_load(input logic [13:0] v, input logic [15:0] e, input bit push);
    load  = 1'b1;
    value = v;
    if (push) sb.push_back(e);
    @(negedge sysclk);
    load = 1'b0;
  endtask

  // Count busy cycles until it falls, optionally injecting a load mid-conversion
  task automatic wait_done(input int inj_at, input logic [13:0] inj_val);
    int cnt = 0;
    bit done = 1'b0;
    logic [15:0] e;
    for (int i = 0; i < 40 && !done; i++) begin
      if (i == inj_at) begin
        load  = 1'b1;
        value = inj_val;
      end else begin
        load = 1'b0;
      end
      if (busy_a) cnt++;
      else        done = 1'b1;
      if (!done) @(negedge sysclk);
    end
    load = 1'b0;
    chk("busy_fell", {31'd0, done}, 32'd1);
    chk("busy_len", 32'(cnt), 32'd14);
    chk("busy_b", {31'd0, busy_b}, 32'd0);
    chk("sb_size", 32'(sb.size()), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("bcd_lzb1", {16'd0, bcd_a}, {16'd0, e});
      chk("bcd_lzb0", {16'd0, bcd_b}, {16'd0, e});
    end
  endtask

  task automatic convert(input logic [13:0] v, input logic [15:0] e);
    start_load(v, e, 1'b1);
    wait_done(-1, 14'd0);
    @(negedge sysclk);
    check_disp(16, e, -1, -1);
  endtask

  initial begin
    repeat (2) @(negedge sysclk);
    chk("rst_out_a", {20'd0, an_a, leds_a}, 32'hFFF);
    chk("rst_out_b", {20'd0, an_b, leds_b}, 32'hFFF);
    chk("rst_bcd", {16'd0, bcd_a}, 32'd0);
    chk("rst_busy", {31'd0, busy_a}, 32'd0);
    repeat (8) @(negedge sysclk);
    reset = 1'b0;

    check_disp(16, 16'h0000, -1, -1);
    chk("idle_busy", {31'd0, busy_a}, 32'd0);

    convert(14'd1234, 16'h1234);
    convert(14'd10000, 16'h9999);
    convert(14'd16383, 16'h9999);
    convert(14'd7, 16'h0007);

    // Second load during conversion is dropped; a load on the first idle cycle is taken
    start_load(14'd1234, 16'h1234, 1'b1);
    wait_done(3, 14'd5678);
    start_load(14'd5678, 16'h5678, 1'b1);
    wait_done(-1, 14'd0);
    @(negedge sysclk);
    check_disp(16, 16'h5678, -1, -1);

    check_disp(40, 16'h5678, 4, 24);

    // Reset on the 5th cycle of a conversion
    start_load(14'd4321, 16'h4321, 1'b0);
    repeat (4) @(negedge sysclk);
    reset = 1'b1;
    #1;
    chk("abort_busy", {31'd0, busy_a}, 32'd0);
    chk("abort_bcd_a", {16'd0, bcd_a}, 32'd0);
    chk("abort_bcd_b", {16'd0, bcd_b}, 32'd0);
    chk("abort_out", {20'd0, an_a, leds_a}, 32'hFFF);
    repeat (2) @(negedge sysclk);
    reset = 1'b0;
    repeat (20) @(negedge sysclk);
    chk("post_busy", {31'd0, busy_a}, 32'd0);
    chk("post_bcd", {16'd0, bcd_a}, 32'd0);
    check_disp(16, 16'h0000, -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
